// File: rtl/cpu_pkg.sv
// Shared constants and types for cpu_core: opcodes, FSM states, ALU ops and flag positions.
// Optional feature macro: CPU_COND_JUMP_EN (consumed by cpu_core).
package cpu_pkg;

  localparam logic [7:0] OpAdd  = 8'h02;
  localparam logic [7:0] OpSub  = 8'h22;
  localparam logic [7:0] OpAnd  = 8'h52;
  localparam logic [7:0] OpOr   = 8'h42;
  localparam logic [7:0] OpXor  = 8'hB2;
  localparam logic [7:0] OpJmp  = 8'h8D;
  localparam logic [7:0] OpJz   = 8'h6D;
  localparam logic [7:0] OpJc   = 8'h7D;
  localparam logic [7:0] OpHalt = 8'h7F;

  // Low-nibble patterns of the register-indexed load family (x8, xC).
  localparam logic [3:0] LoLdReg = 4'h8;
  localparam logic [3:0] LoLdImm = 4'hC;

  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagC = 1;

  typedef enum logic [1:0] {
    StFetch0,
    StFetch1,
    StExec,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    AluLd,
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor
  } alu_op_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for cpu_core: pass-through load, ADD/SUB with carry/borrow, bitwise ops.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_res,
  output logic              o_c,
  output logic              o_z
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the widened difference is the borrow, i.e. i_a < i_b.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_res = i_b;
    o_c   = 1'b0;
    case (alu_op_e'(i_op))
      AluAdd: begin
        o_res = w_sum[DATA_W-1:0];
        o_c   = w_sum[DATA_W];
      end
      AluSub: begin
        o_res = w_diff[DATA_W-1:0];
        o_c   = w_diff[DATA_W];
      end
      AluAnd:  o_res = i_a & i_b;
      AluOr:   o_res = i_a | i_b;
      AluXor:  o_res = i_a ^ i_b;
      default: o_res = i_b;
    endcase
  end

  assign o_z = (o_res == '0);

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle CPU core: 2-byte fetch over a ready/valid read port, register file, Z/C flags.
// Define CPU_COND_JUMP_EN to enable the 6D/7D conditional jumps; otherwise they are NOPs.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned REG_CNT = 16,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  input  logic [3:0]        dbg_reg_sel,
  output logic [DATA_W-1:0] dbg_reg_data,
  output logic [1:0]        dbg_flags
);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir0;
  logic [7:0]        r_ir1;
  logic [DATA_W-1:0] r_regs [REG_CNT];
  logic [1:0]        r_flags;

  logic              w_accept;
  logic [DATA_W-1:0] w_rf [16];
  logic [3:0]        w_hi;
  logic [3:0]        w_lo;
  logic [3:0]        w_dh;
  logic [3:0]        w_dl;

  logic [2:0]        w_alu_op;
  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;
  logic              w_alu_z;
  logic              w_wr_en;
  logic [3:0]        w_wr_idx;
  logic              w_flag_en;
  logic              w_jump;
  logic              w_halt;

  // Full 16-entry read view; indices beyond REG_CNT read as zero.
  for (genvar g = 0; g < 16; g++) begin : g_rf_view
    if (g < REG_CNT) begin : g_real
      assign w_rf[g] = r_regs[g];
    end else begin : g_zero
      assign w_rf[g] = '0;
    end
  end

  assign w_hi = r_ir0[7:4];
  assign w_lo = r_ir0[3:0];
  assign w_dh = r_ir1[7:4];
  assign w_dl = r_ir1[3:0];

  // Gated by reset so an in-flight request drops the moment reset is asserted.
  assign mem_rd   = ~reset & ((r_state == StFetch0) | (r_state == StFetch1));
  assign mem_addr = r_pc;
  assign w_accept = mem_rd & mem_ready;

  assign halted       = (r_state == StHalt);
  assign dbg_reg_data = w_rf[dbg_reg_sel];
  assign dbg_flags    = r_flags;
  assign w_alu_a      = w_rf[w_dh];

  always_comb begin
    w_alu_op  = AluLd;
    w_alu_b   = w_rf[w_dl];
    w_wr_en   = 1'b0;
    w_wr_idx  = w_dh;
    w_flag_en = 1'b0;
    w_jump    = 1'b0;
    w_halt    = 1'b0;
    case (r_ir0)
      OpAdd: begin w_alu_op = AluAdd; w_wr_en = 1'b1; w_flag_en = 1'b1; end
      OpSub: begin w_alu_op = AluSub; w_wr_en = 1'b1; w_flag_en = 1'b1; end
      OpAnd: begin w_alu_op = AluAnd; w_wr_en = 1'b1; w_flag_en = 1'b1; end
      OpOr:  begin w_alu_op = AluOr;  w_wr_en = 1'b1; w_flag_en = 1'b1; end
      OpXor: begin w_alu_op = AluXor; w_wr_en = 1'b1; w_flag_en = 1'b1; end
      OpJmp: w_jump = 1'b1;
      OpJz: begin
`ifdef CPU_COND_JUMP_EN
        w_jump = r_flags[FlagZ];
`else
        w_jump = 1'b0;
`endif
      end
      OpJc: begin
`ifdef CPU_COND_JUMP_EN
        w_jump = r_flags[FlagC];
`else
        w_jump = 1'b0;
`endif
      end
      OpHalt: w_halt = 1'b1;
      default: begin
        if (w_lo == LoLdReg) begin
          w_wr_en  = 1'b1;
          w_wr_idx = w_hi;
        end else if (w_lo == LoLdImm) begin
          w_wr_en  = 1'b1;
          w_wr_idx = w_hi;
          w_alu_b  = DATA_W'(r_ir1);
        end
      end
    endcase
  end

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op  (w_alu_op),
    .i_a   (w_alu_a),
    .i_b   (w_alu_b),
    .o_res (w_alu_res),
    .o_c   (w_alu_c),
    .o_z   (w_alu_z)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch0: if (w_accept) w_state_next = StFetch1;
      StFetch1: if (w_accept) w_state_next = StExec;
      StExec:   w_state_next = w_halt ? StHalt : StFetch0;
      StHalt:   w_state_next = StHalt;
      default:  w_state_next = StFetch0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StFetch0;
      r_pc    <= '0;
      r_ir0   <= '0;
      r_ir1   <= '0;
      r_flags <= '0;
      for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_pc <= r_pc + ADDR_W'(1);
        if (r_state == StFetch0) r_ir0 <= mem_rdata;
        else                     r_ir1 <= mem_rdata;
      end
      if (r_state == StExec) begin
        // Writes to indices >= REG_CNT match no entry and are dropped.
        for (int i = 0; i < REG_CNT; i++) begin
          if (w_wr_en && (w_wr_idx == 4'(i))) r_regs[i] <= w_alu_res;
        end
        if (w_flag_en) r_flags <= {w_alu_c, w_alu_z};
        if (w_jump)    r_pc    <= ADDR_W'(r_ir1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: ALU vector table, directed timing/corner sequences,
// and random programs checked against an instruction-level model.
`timescale 1ns/1ps
module tb_cpu_core;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned REG_CNT = 16;
  localparam int unsigned ADDR_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_ready;
  logic              halted;
  logic [3:0]        dbg_reg_sel = 4'd0;
  logic [DATA_W-1:0] dbg_reg_data;
  logic [1:0]        dbg_flags;

  cpu_core #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .halted       (halted),
    .dbg_reg_sel  (dbg_reg_sel),
    .dbg_reg_data (dbg_reg_data),
    .dbg_flags    (dbg_flags)
  );

  always #5 clk = ~clk;

  // Program memory with programmable wait states per byte.
  logic [7:0] mem [256];
  int  fixed_waits = 0;
  bit  rand_waits  = 1'b0;
  bit  hold_ready  = 1'b0;
  int  cur_wait;
  int  wcnt;
  logic [7:0] acc_q [$];

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = !hold_ready && (wcnt >= cur_wait);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt     <= 0;
      cur_wait <= rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
    end else if (mem_rd && mem_ready) begin
      wcnt     <= 0;
      cur_wait <= rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
    end else if (mem_rd) begin
      wcnt <= wcnt + 1;
    end
  end

  always @(posedge clk) begin
    if (!reset && mem_rd && mem_ready) acc_q.push_back(mem_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic rdreg(input int idx, output int v);
    dbg_reg_sel = 4'(idx);
    @(negedge clk);
    v = int'(dbg_reg_data);
  endtask

  task automatic chk_reg(input string nm, input int idx, input int exp);
    int v;
    rdreg(idx, v);
    chk(nm, v, exp);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h7F;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    acc_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int stab_err;

  // Counts cycles after reset release until halted; flags request instability during waits.
  task automatic run_to_halt(input int limit, output int cyc);
    bit         pv_wait;
    logic [7:0] pv_addr;
    cyc      = 0;
    stab_err = 0;
    pv_wait  = mem_rd && !mem_ready;
    pv_addr  = mem_addr;
    while (!halted && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pv_wait && (!mem_rd || mem_addr != pv_addr)) stab_err++;
      pv_wait = mem_rd && !mem_ready;
      pv_addr = mem_addr;
    end
    if (!halted) begin
      errors++;
      checks++;
      $display("FAIL halt_timeout: no halt after %0d cycles", limit);
    end
  endtask

  // Instruction-level reference model: interprets memory directly.
  int m_r [16];
  int m_z, m_c, m_pc;

  task automatic iss_run();
    int b0, b1, hi, lo, dh, dl, a, b, res;
    bit done;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    m_z = 0; m_c = 0; m_pc = 0; done = 0;
    for (int s = 0; s < 1000 && !done; s++) begin
      b0 = int'(mem[m_pc]);
      b1 = int'(mem[(m_pc + 1) % 256]);
      m_pc = (m_pc + 2) % 256;
      hi = b0 / 16; lo = b0 % 16; dh = b1 / 16; dl = b1 % 16;
      a = m_r[dh]; b = m_r[dl];
      if (b0 == 'h02 || b0 == 'h22 || b0 == 'h52 || b0 == 'h42 || b0 == 'hB2) begin
        m_c = 0;
        if (b0 == 'h02) begin res = a + b; m_c = (res > 255) ? 1 : 0; res = res % 256; end
        else if (b0 == 'h22) begin m_c = (a < b) ? 1 : 0; res = (a - b + 256) % 256; end
        else if (b0 == 'h52) res = a & b;
        else if (b0 == 'h42) res = a | b;
        else res = a ^ b;
        m_z = (res == 0) ? 1 : 0;
        m_r[dh] = res;
      end else if (b0 == 'h8D) m_pc = b1;
      else if (b0 == 'h6D) begin
`ifdef CPU_COND_JUMP_EN
        if (m_z != 0) m_pc = b1;
`endif
      end else if (b0 == 'h7D) begin
`ifdef CPU_COND_JUMP_EN
        if (m_c != 0) m_pc = b1;
`endif
      end else if (b0 == 'h7F) done = 1;
      else if (lo == 8) m_r[hi] = m_r[dl];
      else if (lo == 12) m_r[hi] = b1;
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;

  vec_t       vt [8];
  logic [7:0] nops [4];

  initial begin
    int cyc, v;
    int pc_end;
    logic [7:0] b0, b1;
    int a, t;

    vt[0] = '{"add_carry", 8'h02, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
    vt[1] = '{"add_plain", 8'h02, 8'd10,  8'd20,  8'd30,  1'b0, 1'b0};
    vt[2] = '{"add_zero",  8'h02, 8'd128, 8'd128, 8'd0,   1'b1, 1'b1};
    vt[3] = '{"sub_zero",  8'h22, 8'd5,   8'd5,   8'd0,   1'b0, 1'b1};
    vt[4] = '{"sub_borr",  8'h22, 8'd3,   8'd5,   8'd254, 1'b1, 1'b0};
    vt[5] = '{"and_zero",  8'h52, 8'hF0,  8'h0F,  8'h00,  1'b0, 1'b1};
    vt[6] = '{"or_ff",     8'h42, 8'hF0,  8'h0F,  8'hFF,  1'b0, 1'b0};
    vt[7] = '{"xor_55",    8'hB2, 8'hAA,  8'hFF,  8'h55,  1'b0, 1'b0};
    nops = '{8'h00, 8'h13, 8'hA1, 8'hFF};

    // Reset state
    fill_mem();
    #1 reset = 1'b1;
    #2;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_flags", dbg_flags, 0);
    chk("rst_r0", dbg_reg_data, 0);

    // Base program, zero wait states
    mem[0] = 8'h0C; mem[1] = 8'h0A; mem[2] = 8'h1C; mem[3] = 8'h14;
    mem[4] = 8'h02; mem[5] = 8'h01; mem[6] = 8'h7F; mem[7] = 8'h00;
    fixed_waits = 0;
    reset_dut();
    #1 chk("rd_after_release", mem_rd, 1);
    run_to_halt(200, cyc);
    chk("base_cycles", cyc, 12);
    chk("base_pc", mem_addr, 8);
    chk("base_rd_halt", mem_rd, 0);
    chk("base_flags", dbg_flags, 0);
    chk_reg("base_r0", 0, 30);
    chk_reg("base_r1", 1, 20);

    // Same program, two wait cycles per byte
    fixed_waits = 2;
    reset_dut();
    run_to_halt(400, cyc);
    chk("wait_cycles", cyc, 4 * (3 + 2 * 2));
    chk("wait_stable", stab_err, 0);
    chk("wait_pc", mem_addr, 8);
    chk_reg("wait_r0", 0, 30);
    chk_reg("wait_r1", 1, 20);
    fixed_waits = 0;

    // ALU vector table
    for (int i = 0; i < 8; i++) begin
      fill_mem();
      mem[0] = 8'h0C; mem[1] = vt[i].a; mem[2] = 8'h1C; mem[3] = vt[i].b;
      mem[4] = vt[i].op; mem[5] = 8'h01;
      reset_dut();
      run_to_halt(200, cyc);
      chk_reg({vt[i].name, "_res"}, 0, int'(vt[i].res));
      chk_reg({vt[i].name, "_r1"}, 1, int'(vt[i].b));
      chk({vt[i].name, "_flags"}, dbg_flags, {vt[i].c, vt[i].z});
    end

    // ADD with carry then SUB to self
    fill_mem();
    mem[0] = 8'h0C; mem[1] = 8'd200; mem[2] = 8'h1C; mem[3] = 8'd100;
    mem[4] = 8'h02; mem[5] = 8'h01; mem[6] = 8'h2C; mem[7] = 8'h05;
    mem[8] = 8'h22; mem[9] = 8'h22;
    reset_dut();
    run_to_halt(200, cyc);
    chk_reg("addsub_r0", 0, 44);
    chk_reg("addsub_r2", 2, 0);
    chk("addsub_flags", dbg_flags, 2'b01);

    // Conditional jumps: 7D with C=0, then 6D with Z=1
    fill_mem();
    mem[0] = 8'h0C; mem[1] = 8'h05; mem[2] = 8'h22; mem[3] = 8'h00;
    mem[4] = 8'h7D; mem[5] = 8'h30; mem[6] = 8'h6D; mem[7] = 8'h20;
    mem[8] = 8'h1C; mem[9] = 8'h11;
    mem[8'h20] = 8'h2C; mem[8'h21] = 8'h22;
    mem[8'h30] = 8'h3C; mem[8'h31] = 8'h99;
    reset_dut();
    run_to_halt(200, cyc);
    chk_reg("jc_not_taken_r3", 3, 0);
`ifdef CPU_COND_JUMP_EN
    chk("jz_pc", mem_addr, 8'h24);
    chk_reg("jz_r2", 2, 8'h22);
    chk_reg("jz_r1", 1, 0);
`else
    chk("jz_pc", mem_addr, 8'h0C);
    chk_reg("jz_r2", 2, 0);
    chk_reg("jz_r1", 1, 8'h11);
`endif
    chk("jz_flags", dbg_flags, 2'b01);

    // Jump near the top of memory; the HALT straddles the address wrap
    fill_mem();
    mem[0] = 8'h8D; mem[1] = 8'hFD;
    mem[8'hFD] = 8'h0C; mem[8'hFE] = 8'h33; mem[8'hFF] = 8'h7F;
    reset_dut();
    run_to_halt(200, cyc);
    chk("wrap_cycles", cyc, 9);
    chk("wrap_pc", mem_addr, 1);
    chk("wrap_nfetch", acc_q.size(), 6);
    if (acc_q.size() == 6) begin
      chk("wrap_addr3", acc_q[3], 8'hFE);
      chk("wrap_addr4", acc_q[4], 8'hFF);
      chk("wrap_addr5", acc_q[5], 8'h00);
    end
    chk_reg("wrap_r0", 0, 8'h33);

    // Reset asserted during a stalled operand fetch
    fill_mem();
    mem[0] = 8'h0C; mem[1] = 8'h0A; mem[2] = 8'h1C; mem[3] = 8'h14;
    mem[4] = 8'h02; mem[5] = 8'h01;
    dbg_reg_sel = 4'd0;
    reset_dut();
    repeat (4) @(posedge clk);
    #1 hold_ready = 1'b1;
    @(negedge clk);
    chk("mid_rd_pre", mem_rd, 1);
    chk("mid_addr_pre", mem_addr, 3);
    chk("mid_r0_pre", dbg_reg_data, 10);
    #1 reset = 1'b1;
    #1;
    chk("mid_rd_drop", mem_rd, 0);
    chk("mid_addr_rst", mem_addr, 0);
    chk("mid_r0_rst", dbg_reg_data, 0);
    chk("mid_flags_rst", dbg_flags, 0);
    @(negedge clk);
    acc_q.delete();
    reset = 1'b0;
    hold_ready = 1'b0;
    run_to_halt(200, cyc);
    chk("mid_refetch0", (acc_q.size() > 0) ? int'(acc_q[0]) : -1, 0);
    chk("mid_cycles", cyc, 12);
    chk_reg("mid_r0", 0, 30);

    // Random programs with random wait states vs. the reference model
    rand_waits = 1'b1;
    for (int p = 0; p < 25; p++) begin
      fill_mem();
      a = 0;
      for (int i = 0; i < 14; i++) begin
        t  = int'($urandom_range(0, 9));
        b1 = 8'($urandom);
        case (t)
          0: b0 = 8'h02;
          1: b0 = 8'h22;
          2: b0 = 8'h52;
          3: b0 = 8'h42;
          4: b0 = 8'hB2;
          5: b0 = {4'($urandom), 4'h8};
          6, 7, 8: b0 = {4'($urandom), 4'hC};
          default: b0 = nops[$urandom_range(0, 3)];
        endcase
        mem[a] = b0; mem[a + 1] = b1;
        a += 2;
      end
      iss_run();
      pc_end = m_pc;
      reset_dut();
      run_to_halt(2000, cyc);
      chk($sformatf("rnd%0d_pc", p), mem_addr, pc_end);
      chk($sformatf("rnd%0d_flags", p), dbg_flags, m_c * 2 + m_z);
      chk($sformatf("rnd%0d_stable", p), stab_err, 0);
      for (int r = 0; r < 16; r++) begin
        rdreg(r, v);
        chk($sformatf("rnd%0d_r%0d", p, r), v, m_r[r]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
